// File: rtl/agp32_mem_ctrl.sv
// agp32 MEM-stage controller: one request at a time, drives the data-memory command bus,
// runs the half-sum accelerator and the interrupt handshake. Optional macro: AGP32_MEM_ERR_RECOVER_EN.
module agp32_mem_ctrl #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int ACC_LATENCY = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   input  logic [2:0]          req_op,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                req_ready,
   output logic                stall,
   input  logic                mem_ready,
   input  logic                mem_start_ready,
   input  logic [1:0]          mem_error,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic [2:0]          command,
   output logic [ADDR_W-1:0]   data_addr,
   output logic [DATA_W-1:0]   data_wdata,
   output logic [DATA_W/8-1:0] data_wstrb,
   output logic [DATA_W-1:0]   resp_data,
   output logic                resp_valid,
   output logic                interrupt_req,
   input  logic                interrupt_ack
);

   localparam int NB     = DATA_W / 8;
   localparam int LANE_W = (NB > 1) ? $clog2(NB) : 1;
   localparam int HALF   = DATA_W / 2;
   localparam int CNT_W  = $clog2(ACC_LATENCY + 1);

   localparam logic [2:0] OP_LW  = 3'd1;
   localparam logic [2:0] OP_LB  = 3'd2;
   localparam logic [2:0] OP_SW  = 3'd3;
   localparam logic [2:0] OP_SB  = 3'd4;
   localparam logic [2:0] OP_ACC = 3'd5;
   localparam logic [2:0] OP_INT = 3'd6;

   localparam logic [2:0] CMD_IDLE    = 3'd0;
   localparam logic [2:0] CMD_REFRESH = 3'd1;
   localparam logic [2:0] CMD_READ    = 3'd2;
   localparam logic [2:0] CMD_WRITE   = 3'd3;
   localparam logic [2:0] CMD_INT     = 3'd4;

   localparam logic [1:0] LD_NONE = 2'd0;
   localparam logic [1:0] LD_WORD = 2'd1;
   localparam logic [1:0] LD_BYTE = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_MEM = 3'd1,
      S_WAIT_ACC = 3'd2,
      S_INIT     = 3'd3,
      S_WAIT_INT = 3'd4,
      S_ERROR    = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          command_q, command_d;
   logic [ADDR_W-1:0]   data_addr_q, data_addr_d;
   logic [DATA_W-1:0]   data_wdata_q, data_wdata_d;
   logic [NB-1:0]       data_wstrb_q, data_wstrb_d;
   logic [DATA_W-1:0]   resp_data_q, resp_data_d;
   logic                resp_valid_q, resp_valid_d;
   logic                interrupt_req_q, interrupt_req_d;
   logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
   logic [DATA_W-1:0]   acc_arg_q, acc_arg_d;
   logic                do_int_q, do_int_d;
   logic [1:0]          ld_kind_q, ld_kind_d;
   logic [LANE_W-1:0]   ld_lane_q, ld_lane_d;
`ifdef AGP32_MEM_ERR_RECOVER_EN
   logic [2:0]          err_cnt_q, err_cnt_d;
`endif

   logic [HALF-1:0]     acc_sum;
   logic [LANE_W-1:0]   req_lane;
   logic                err_now;

   assign err_now   = (mem_error != 2'b00);
   assign req_ready = (state_q == S_IDLE) && mem_ready && !err_now;
   assign stall     = !req_ready;
   assign acc_sum   = acc_arg_q[DATA_W-1:HALF] + acc_arg_q[HALF-1:0];
   assign req_lane  = req_addr[LANE_W-1:0];

   always_comb begin
      state_d         = state_q;
      command_d       = command_q;
      data_addr_d     = data_addr_q;
      data_wdata_d    = data_wdata_q;
      data_wstrb_d    = data_wstrb_q;
      resp_data_d     = resp_data_q;
      resp_valid_d    = 1'b0;
      interrupt_req_d = interrupt_req_q;
      acc_cnt_d       = acc_cnt_q;
      acc_arg_d       = acc_arg_q;
      do_int_d        = do_int_q;
      ld_kind_d       = ld_kind_q;
      ld_lane_d       = ld_lane_q;
`ifdef AGP32_MEM_ERR_RECOVER_EN
      err_cnt_d       = err_cnt_q;
`endif
      // A memory error beats every other transition, whatever the state.
      if (err_now) begin
         state_d   = S_ERROR;
         command_d = CMD_IDLE;
`ifdef AGP32_MEM_ERR_RECOVER_EN
         err_cnt_d = 3'd0;
`endif
      end else begin
         case (state_q)
            S_INIT: begin
               if (mem_start_ready) begin
                  state_d   = S_WAIT_MEM;
                  command_d = CMD_REFRESH;
               end
            end
            S_IDLE: begin
               command_d = CMD_IDLE;
               if (!mem_ready) begin
                  state_d = S_WAIT_MEM;
               end else if (req_valid) begin
                  case (req_op)
                     OP_INT: begin
                        command_d   = CMD_INT;
                        data_addr_d = '0;
                        do_int_d    = 1'b1;
                        state_d     = S_WAIT_MEM;
                     end
                     OP_LW, OP_LB: begin
                        command_d   = CMD_READ;
                        data_addr_d = req_addr;
                        ld_kind_d   = (req_op == OP_LW) ? LD_WORD : LD_BYTE;
                        ld_lane_d   = req_lane;
                        state_d     = S_WAIT_MEM;
                     end
                     OP_SW: begin
                        command_d    = CMD_WRITE;
                        data_addr_d  = req_addr;
                        data_wdata_d = req_wdata;
                        data_wstrb_d = '1;
                        state_d      = S_WAIT_MEM;
                     end
                     OP_SB: begin
                        command_d              = CMD_WRITE;
                        data_addr_d            = req_addr;
                        data_wdata_d           = {NB{req_wdata[7:0]}};
                        data_wstrb_d           = '0;
                        data_wstrb_d[req_lane] = 1'b1;
                        state_d                = S_WAIT_MEM;
                     end
                     OP_ACC: begin
                        acc_arg_d = req_wdata;
                        acc_cnt_d = CNT_W'(ACC_LATENCY);
                        command_d = CMD_REFRESH;
                        state_d   = S_WAIT_ACC;
                     end
                     default: command_d = CMD_REFRESH;
                  endcase
               end
            end
            S_WAIT_MEM: begin
               command_d = CMD_IDLE;
               // Exit only once the issued command has been on the bus for its single cycle.
               if (mem_ready && (command_q == CMD_IDLE)) begin
                  if (do_int_q) begin
                     state_d         = S_WAIT_INT;
                     interrupt_req_d = 1'b1;
                     do_int_d        = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
                  if (ld_kind_q == LD_WORD) begin
                     resp_valid_d = 1'b1;
                     resp_data_d  = mem_rdata;
                  end else if (ld_kind_q == LD_BYTE) begin
                     resp_valid_d = 1'b1;
                     resp_data_d  = {{(DATA_W-8){1'b0}}, mem_rdata[{ld_lane_q, 3'b000} +: 8]};
                  end
                  ld_kind_d = LD_NONE;
               end
            end
            S_WAIT_ACC: begin
               command_d = CMD_IDLE;
               if (acc_cnt_q == '0) begin
                  resp_valid_d = 1'b1;
                  resp_data_d  = {{(DATA_W-HALF){1'b0}}, acc_sum};
                  state_d      = S_IDLE;
               end else begin
                  acc_cnt_d = acc_cnt_q - 1'b1;
               end
            end
            S_WAIT_INT: begin
               command_d = CMD_IDLE;
               if (interrupt_ack) begin
                  interrupt_req_d = 1'b0;
                  state_d         = S_IDLE;
               end
            end
            S_ERROR: begin
               command_d = CMD_IDLE;
`ifdef AGP32_MEM_ERR_RECOVER_EN
               // Four clean cycles in a row before re-initialising the memory.
               if (err_cnt_q == 3'd3) begin
                  state_d         = S_INIT;
                  err_cnt_d       = 3'd0;
                  data_addr_d     = '1;
                  data_wstrb_d    = '0;
                  interrupt_req_d = 1'b0;
                  do_int_d        = 1'b0;
                  ld_kind_d       = LD_NONE;
               end else begin
                  err_cnt_d = err_cnt_q + 3'd1;
               end
`endif
            end
            default: state_d = S_INIT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_INIT;
         command_q       <= CMD_IDLE;
         data_addr_q     <= '1;
         data_wdata_q    <= '0;
         data_wstrb_q    <= '0;
         resp_data_q     <= '0;
         resp_valid_q    <= 1'b0;
         interrupt_req_q <= 1'b0;
         acc_cnt_q       <= '0;
         acc_arg_q       <= '0;
         do_int_q        <= 1'b0;
         ld_kind_q       <= LD_NONE;
         ld_lane_q       <= '0;
`ifdef AGP32_MEM_ERR_RECOVER_EN
         err_cnt_q       <= 3'd0;
`endif
      end else begin
         state_q         <= state_d;
         command_q       <= command_d;
         data_addr_q     <= data_addr_d;
         data_wdata_q    <= data_wdata_d;
         data_wstrb_q    <= data_wstrb_d;
         resp_data_q     <= resp_data_d;
         resp_valid_q    <= resp_valid_d;
         interrupt_req_q <= interrupt_req_d;
         acc_cnt_q       <= acc_cnt_d;
         acc_arg_q       <= acc_arg_d;
         do_int_q        <= do_int_d;
         ld_kind_q       <= ld_kind_d;
         ld_lane_q       <= ld_lane_d;
`ifdef AGP32_MEM_ERR_RECOVER_EN
         err_cnt_q       <= err_cnt_d;
`endif
      end
   end

   assign command       = command_q;
   assign data_addr     = data_addr_q;
   assign data_wdata    = data_wdata_q;
   assign data_wstrb    = data_wstrb_q;
   assign resp_data     = resp_data_q;
   assign resp_valid    = resp_valid_q;
   assign interrupt_req = interrupt_req_q;

endmodule

// File: tb/tb_agp32_mem_ctrl.sv
// Bench for agp32_mem_ctrl: directed literal checks, then random traffic against a
// transaction-level model (busy countdowns and a pending-load record).
module tb_agp32_mem_ctrl;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int LAT = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          req_valid, req_ready, stall;
   logic [2:0]    req_op;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          mem_ready, mem_start_ready;
   logic [1:0]    mem_error;
   logic [DW-1:0] mem_rdata;
   logic [2:0]    command;
   logic [AW-1:0] data_addr;
   logic [DW-1:0] data_wdata;
   logic [DW/8-1:0] data_wstrb;
   logic [DW-1:0] resp_data;
   logic          resp_valid, interrupt_req, interrupt_ack;

   always #5 clk = ~clk;

   agp32_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .ACC_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .stall(stall), .mem_ready(mem_ready),
      .mem_start_ready(mem_start_ready), .mem_error(mem_error), .mem_rdata(mem_rdata),
      .command(command), .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
      .resp_data(resp_data), .resp_valid(resp_valid), .interrupt_req(interrupt_req),
      .interrupt_ack(interrupt_ack)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic quiet;
      req_valid = 1'b0; req_op = 3'd0; req_addr = '0; req_wdata = '0;
      interrupt_ack = 1'b0; mem_error = 2'b00;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
      req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
   endtask

   // Reset pulse then walk through INIT -> WAIT_MEM (refresh) -> IDLE.
   task automatic reset_to_idle;
      rst_n = 1'b0;
      quiet();
      mem_ready = 1'b1; mem_start_ready = 1'b1; mem_rdata = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick(); tick(); tick();
   endtask

   // ---------------- transaction-level model ----------------
   localparam int K_NONE = 0, K_LW = 1, K_LB = 2, K_INT = 3;
   int            m_acc_left, m_hold, m_kind;
   bit            m_mem_wait, m_in_int;
   logic [2:0]    m_cmd;
   logic [31:0]   m_addr, m_wdata, m_arg, m_rdata;
   logic [3:0]    m_wstrb;
   logic [1:0]    m_lane;
   logic          m_rv, m_int;

   function automatic bit m_idle();
      return !m_in_int && (m_acc_left == 0) && !m_mem_wait;
   endfunction

   task automatic model_reset;
      m_acc_left = 0; m_hold = 0; m_kind = K_NONE; m_mem_wait = 0; m_in_int = 0;
      m_cmd = 3'd0; m_addr = 32'hFFFF_FFFF; m_wdata = '0; m_wstrb = '0; m_arg = '0;
      m_rdata = '0; m_lane = '0; m_rv = 1'b0; m_int = 1'b0;
   endtask

   // One clock edge of the model, reading only bench-driven inputs.
   task automatic model_step;
      m_cmd = 3'd0;
      m_rv  = 1'b0;
      if (m_in_int) begin
         if (interrupt_ack) begin m_in_int = 0; m_int = 1'b0; end
      end else if (m_acc_left > 0) begin
         m_acc_left--;
         if (m_acc_left == 0) begin
            m_rv = 1'b1;
            m_rdata = ((m_arg >> 16) + (m_arg & 32'hFFFF)) & 32'hFFFF;
         end
      end else if (m_mem_wait) begin
         if (m_hold > 0) m_hold--;
         else if (mem_ready) begin
            m_mem_wait = 0;
            if (m_kind == K_LW) begin m_rv = 1'b1; m_rdata = mem_rdata; end
            if (m_kind == K_LB) begin m_rv = 1'b1; m_rdata = (mem_rdata >> (8 * m_lane)) & 32'hFF; end
            if (m_kind == K_INT) begin m_in_int = 1; m_int = 1'b1; end
            m_kind = K_NONE;
         end
      end else if (!mem_ready) begin
         m_mem_wait = 1; m_hold = 0; m_kind = K_NONE;
      end else if (req_valid) begin
         case (req_op)
            3'd1, 3'd2: begin
               m_cmd = 3'd2; m_addr = req_addr; m_mem_wait = 1; m_hold = 1;
               m_kind = (req_op == 3'd1) ? K_LW : K_LB; m_lane = req_addr[1:0];
            end
            3'd3: begin
               m_cmd = 3'd3; m_addr = req_addr; m_wdata = req_wdata; m_wstrb = 4'hF;
               m_mem_wait = 1; m_hold = 1; m_kind = K_NONE;
            end
            3'd4: begin
               m_cmd = 3'd3; m_addr = req_addr; m_wdata = {24'd0, req_wdata[7:0]} * 32'h0101_0101;
               m_wstrb = 4'(1 << req_addr[1:0]); m_mem_wait = 1; m_hold = 1; m_kind = K_NONE;
            end
            3'd5: begin m_cmd = 3'd1; m_arg = req_wdata; m_acc_left = LAT + 1; end
            3'd6: begin m_cmd = 3'd4; m_addr = '0; m_mem_wait = 1; m_hold = 1; m_kind = K_INT; end
            default: m_cmd = 3'd1;
         endcase
      end
   endtask

   task automatic compare;
      logic er;
      er = m_idle() && mem_ready;
      chk("req_ready", req_ready, er);
      chk("stall", stall, !er);
      chk("command", command, m_cmd);
      chk("data_addr", data_addr, m_addr);
      chk("data_wdata", data_wdata, m_wdata);
      chk("data_wstrb", data_wstrb, m_wstrb);
      chk("resp_valid", resp_valid, m_rv);
      chk("resp_data", resp_data, m_rdata);
      chk("interrupt_req", interrupt_req, m_int);
   endtask

   initial begin
      quiet();
      mem_ready = 1'b1; mem_start_ready = 1'b1; mem_rdata = '0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      chk("rst command", command, 3'd0);
      chk("rst data_addr", data_addr, 32'hFFFF_FFFF);
      chk("rst data_wdata", data_wdata, 32'h0);
      chk("rst data_wstrb", data_wstrb, 4'h0);
      chk("rst resp", {resp_valid, resp_data}, 33'h0);
      chk("rst interrupt_req", interrupt_req, 1'b0);
      chk("rst req_ready", req_ready, 1'b0);
      rst_n = 1'b1;
      tick();
      chk("init refresh", command, 3'd1);
      chk("init stall", stall, 1'b1);
      tick();
      chk("init refresh one cycle", command, 3'd0);
      tick();
      chk("idle ready", req_ready, 1'b1);
      chk("idle data_addr", data_addr, 32'hFFFF_FFFF);

      // store byte
      issue(3'd4, 32'h102, 32'hAB);
      tick();
      req_valid = 1'b0;
      chk("sb command", command, 3'd3);
      chk("sb wstrb", data_wstrb, 4'b0100);
      chk("sb wdata", data_wdata, 32'hABAB_ABAB);
      chk("sb addr", data_addr, 32'h102);
      tick();
      chk("sb command drop", command, 3'd0);
      tick();
      chk("sb back idle", req_ready, 1'b1);

      // load byte
      issue(3'd2, 32'h3, 32'h0);
      mem_rdata = 32'h1122_3344;
      tick();
      req_valid = 1'b0;
      chk("lb command", command, 3'd2);
      chk("lb stall 1", stall, 1'b1);
      tick();
      chk("lb stall 2", stall, 1'b1);
      chk("lb no resp yet", resp_valid, 1'b0);
      tick();
      chk("lb resp", {resp_valid, resp_data}, {1'b1, 32'h0000_0011});
      tick();
      chk("lb resp pulse", resp_valid, 1'b0);

      // accelerator
      issue(3'd5, 32'h0, 32'hFFFF_0002);
      tick();
      req_valid = 1'b0;
      chk("acc ready c1", {req_ready, resp_valid}, 2'b00);
      tick();
      chk("acc ready c2", {req_ready, resp_valid}, 2'b00);
      tick();
      chk("acc ready c3", {req_ready, resp_valid}, 2'b00);
      tick();
      chk("acc result", {resp_valid, resp_data}, {1'b1, 32'h1});
      chk("acc back idle", req_ready, 1'b1);

      // interrupt
      issue(3'd6, 32'h1234, 32'h0);
      tick();
      req_valid = 1'b0;
      chk("int command", command, 3'd4);
      chk("int addr", data_addr, 32'h0);
      tick();
      tick();
      chk("int req raised", interrupt_req, 1'b1);
      tick(); tick();
      chk("int req held", {interrupt_req, req_ready}, 2'b10);
      interrupt_ack = 1'b1;
      tick();
      interrupt_ack = 1'b0;
      chk("int ack", {interrupt_req, req_ready}, 2'b01);

      // memory error during WAIT_MEM
      issue(3'd1, 32'h40, 32'h0);
      tick();
      req_valid = 1'b0;
      mem_error = 2'd2;
      tick();
      chk("err command", command, 3'd0);
      chk("err ready", req_ready, 1'b0);
      mem_error = 2'd0;
`ifdef AGP32_MEM_ERR_RECOVER_EN
      tick(); tick(); tick(); tick();
      chk("err recover addr", data_addr, 32'hFFFF_FFFF);
      chk("err recover not ready", req_ready, 1'b0);
      tick();
      chk("err recover refresh", command, 3'd1);
`else
      for (int i = 0; i < 6; i++) tick();
      chk("err sticky", {req_ready, command}, 4'h0);
      chk("err sticky addr", data_addr, 32'h40);
`endif

      // reset mid-store
      reset_to_idle();
      issue(3'd3, 32'h55, 32'h1234_5678);
      tick();
      req_valid = 1'b0;
      chk("sw command", {command, data_wstrb}, {3'd3, 4'hF});
      rst_n = 1'b0;
      #1;
      chk("midreset command", command, 3'd0);
      chk("midreset addr", data_addr, 32'hFFFF_FFFF);
      chk("midreset wdata/wstrb", {data_wdata, data_wstrb}, 36'h0);
      chk("midreset resp/int", {resp_valid, interrupt_req}, 2'b00);

      // random traffic against the model
      reset_to_idle();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         req_valid     = ($urandom_range(0, 1) == 1);
         req_op        = 3'($urandom_range(0, 7));
         req_addr      = $urandom;
         req_wdata     = $urandom;
         mem_rdata     = $urandom;
         mem_ready     = ($urandom_range(0, 4) != 0);
         interrupt_ack = ($urandom_range(0, 2) == 0);
         @(posedge clk);
         model_step();
         @(negedge clk);
         compare();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/agp32_mem_ctrl.md
Name: agp32_mem_ctrl

Overview:
- Parametrised memory-stage controller for the agp32 pipeline: accepts one MEM-stage request at a time, drives the external data-memory command bus, runs the built-in half-sum accelerator, and handles the interrupt handshake.
- Generalised beyond the single-width controller: configurable data/address width and accelerator latency, registered load response with byte-lane extraction, and a stall output for the hazard unit.

Parameters:
- DATA_W, 32, data bus width; multiple of 8, at least 16.
- ADDR_W, 32, data address width.
- ACC_LATENCY, 2, cycles from accelerator launch to result valid; at least 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  MEM stage presents a request.
- req_op  in  3  0 none, 1 load word, 2 load byte, 3 store word, 4 store byte, 5 accelerator, 6 interrupt, 7 none.
- req_addr  in  ADDR_W  load/store address.
- req_wdata  in  DATA_W  store data, or accelerator argument.
- req_ready  out  1  request accepted this cycle when high with req_valid.
- stall  out  1  equals !req_ready.
- mem_ready  in  1  memory idle.
- mem_start_ready  in  1  memory initialised.
- mem_error  in  2  nonzero means fatal memory error.
- mem_rdata  in  DATA_W  read data, valid when a load completes.
- command  out  3  0 idle, 1 refresh, 2 read, 3 write, 4 interrupt.
- data_addr  out  ADDR_W  memory address.
- data_wdata  out  DATA_W  store data.
- data_wstrb  out  DATA_W/8  byte strobes.
- resp_data  out  DATA_W  load or accelerator result.
- resp_valid  out  1  one-cycle pulse with resp_data.
- interrupt_req  out  1  interrupt request to the host.
- interrupt_ack  in  1  host acknowledge.

Behaviour:
- Reset (async, rst_n low):
  - state INIT; command 0; data_addr all ones; data_wdata 0; data_wstrb 0.
  - resp_data 0; resp_valid 0; interrupt_req 0; internal acc counter 0.
  - Applies immediately, including mid-transaction; no pending command survives reset.
- State encodings: IDLE 0, WAIT_MEM 1, WAIT_ACC 2, INIT 3, WAIT_INT 4, ERROR 5.
- mem_error != 0 at a clock edge forces ERROR, from any state, with command <= 0. This overrides every other transition.
- INIT: when mem_start_ready, go to WAIT_MEM with command <= 1.
- req_ready = (state==IDLE) && mem_ready && mem_error==0.
- IDLE with mem_ready low: go to WAIT_MEM, command stays 0.
- IDLE, request accepted, op decode:
  - Op 6: command <= 4, data_addr <= 0, set internal do_int, go to WAIT_MEM.
  - Ops 1, 2: command <= 2, data_addr <= req_addr, go to WAIT_MEM.
  - Op 3: command <= 3, data_addr <= req_addr, data_wdata <= req_wdata, data_wstrb <= all ones, go to WAIT_MEM.
  - Op 4: command <= 3, data_addr <= req_addr.
    - lane = req_addr[log2(DATA_W/8)-1:0]; data_wstrb <= 1<<lane.
    - data_wdata <= req_wdata[7:0] replicated in every lane.
    - Go to WAIT_MEM.
  - Op 5: latch argument, load counter with ACC_LATENCY, command <= 1, go to WAIT_ACC.
  - Ops 0, 7: command <= 1, stay in IDLE, no response.
- WAIT_MEM:
  - command <= 0 on the first cycle, so command is high for exactly one cycle.
  - Leave when mem_ready && command==0.
  - If do_interrupt: go to WAIT_INT, interrupt_req <= 1, clear do_int.
  - Otherwise go to IDLE.
  - On leaving after a load, resp_valid pulses for 1 cycle:
    - load word: resp_data = mem_rdata.
    - load byte: resp_data = zero-extended byte at lane of the latched address.
- WAIT_ACC:
  - command <= 0; counter decrements each cycle.
  - At 0: resp_data = arg[DATA_W-1:DATA_W/2] + arg[DATA_W/2-1:0], mod 2^(DATA_W/2), zero-extended.
  - resp_valid pulses; go to IDLE.
  - Total IDLE-to-IDLE time is ACC_LATENCY+1 cycles.
- WAIT_INT: when interrupt_ack, interrupt_req <= 0, go to IDLE. An ack outside WAIT_INT is ignored.
- Simultaneous req_valid and stall: the request is not consumed; the MEM stage holds it.

Optional Feature:
- Macro: AGP32_MEM_ERR_RECOVER_EN.
- Without it, ERROR is sticky until rst_n.
- With it: ERROR is left after mem_error==0 for 4 consecutive cycles, going to INIT. data_addr is reset to all ones, data_wstrb to 0, and interrupt_req is cleared on entry.

Test Plan:
- Reset with mem_start_ready=1, mem_ready=1 -> command=1 for one cycle after INIT, then IDLE, req_ready=1 and data_addr=0xFFFFFFFF before the first request.
- Store byte with req_addr=0x102, req_wdata=0xAB -> command=3 one cycle, data_wstrb=4'b0100, data_wdata=0xABABABAB, data_addr=0x102.
- Load byte with req_addr=0x3, mem_rdata=0x11223344 -> resp_valid pulse with resp_data=0x00000011; stall high throughout WAIT_MEM.
- Accelerator with req_wdata=0xFFFF0002, ACC_LATENCY=2 -> resp_data=0x00000001 exactly 3 cycles after acceptance; req_ready low in between.
- Interrupt request -> command=4 and data_addr=0, then interrupt_req=1 held until interrupt_ack pulses, then 0, then IDLE.
- mem_error=2 during WAIT_MEM -> ERROR next edge with command=0 and req_ready=0.
  - Without the macro: stays in ERROR.
  - With it: back to INIT 4 cycles after mem_error returns to 0.
  - rst_n low mid-store: all outputs return to reset values immediately.
